// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between the pipeline and the HI/LO multiply-divide unit
interface mult_div_unit_if;
    logic        Start;
    logic [1:0]  MDOperation;
    logic [31:0] A;
    logic [31:0] B;
    logic        HIWrite;
    logic        LOWrite;
    logic [31:0] WriteData;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        Done;
    logic        DivByZero;

    modport master (
        output Start, MDOperation, A, B, HIWrite, LOWrite, WriteData,
        input  HI, LO, Busy, Done, DivByZero
    );

    modport slave (
        input  Start, MDOperation, A, B, HIWrite, LOWrite, WriteData,
        output HI, LO, Busy, Done, DivByZero
    );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 multiply/divide unit with HI/LO registers
// One 64-bit work register serves both ops: {partial, multiplier} or {remainder, quotient}.
module mult_div_unit (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  md
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    state_t      state;
    logic [1:0]  op;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] a_raw;
    logic [31:0] b_mag;
    logic [63:0] work;
    logic [4:0]  count;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;
    logic        dbz_q;

    logic        start_signed;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] mul_sum;
    logic [33:0] div_diff;
    logic [63:0] work_next;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div_zero;

    assign start_signed = ~md.MDOperation[0];
    assign a_abs = (start_signed && md.A[31]) ? -md.A : md.A;
    assign b_abs = (start_signed && md.B[31]) ? -md.B : md.B;

    always_comb begin
        mul_sum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, b_mag} : 33'd0);
        div_diff = {1'b0, work[63:31]} - {2'b00, b_mag};
        if (!op[1])
            work_next = {mul_sum, work[31:1]};
        else if (div_diff[33])
            work_next = {work[62:0], 1'b0};
        else
            work_next = {div_diff[31:0], work[30:0], 1'b1};
    end

    always_comb begin
        res_hi   = work[63:32];
        res_lo   = work[31:0];
        div_zero = op[1] && (b_mag == 32'd0);
        case (op)
            OP_MULT: if (neg_a ^ neg_b) {res_hi, res_lo} = -work;
            OP_DIV: begin
                if (neg_a ^ neg_b) res_lo = -work[31:0];
                if (neg_a)         res_hi = -work[63:32];
            end
            OP_MULTU, OP_DIVU: ;
            default: ;
        endcase
        // Divide by zero reports the raw dividend, not the sign-stripped one.
        if (div_zero) begin
            res_hi = a_raw;
            res_lo = 32'hFFFF_FFFF;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op     <= 2'b00;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            a_raw  <= 32'd0;
            b_mag  <= 32'd0;
            work   <= 64'd0;
            count  <= 5'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (md.HIWrite) hi_q <= md.WriteData;
                    if (md.LOWrite) lo_q <= md.WriteData;
                    if (md.Start) begin
                        op     <= md.MDOperation;
                        neg_a  <= start_signed & md.A[31];
                        neg_b  <= start_signed & md.B[31];
                        a_raw  <= md.A;
                        b_mag  <= b_abs;
                        work   <= {32'd0, a_abs};
                        count  <= 5'd0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    work  <= work_next;
                    count <= count + 5'd1;
                    if (count == 5'd31) state <= FINISH;
                end
                FINISH: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    dbz_q  <= div_zero;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign md.HI        = hi_q;
    assign md.LO        = lo_q;
    assign md.Busy      = busy_q;
    assign md.Done      = done_q;
    assign md.DivByZero = dbz_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;
    logic clk;
    logic reset;
    mult_div_unit_if bus ();

    mult_div_unit dut (.clk(clk), .reset(reset), .md(bus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cycle = 0;
    int   e0    = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb_;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        e.dbz = 1'b0;
        case (op)
            2'b00: begin p = 64'(sa * sb_); e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
                end else if (op == 2'b10) begin
                    p = 64'(sa / sb_); e.lo = p[31:0];
                    p = 64'(sa % sb_); e.hi = p[31:0];
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.Start = 1'b1; bus.MDOperation = op; bus.A = a; bus.B = b;
        sb.push_back(model(op, a, b));
        @(negedge clk);
        bus.Start = 1'b0;
        e0 = cycle;
    endtask

    task automatic wait_result(input string name);
        exp_t e;
        while (bus.Done !== 1'b1 && cycle < e0 + 40) @(negedge clk);
        n_cmp++;
        if (bus.Done !== 1'b1) begin
            n_err++;
            $display("FAIL %s timeout: Done=%b after %0d edges, required 1 after 33", name, bus.Done, cycle - e0);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (cycle - e0 != 33) begin
            n_err++;
            $display("FAIL %s latency: got %0d edges, required 33", name, cycle - e0);
        end
        e = sb.pop_front();
        exp_hi = e.hi; exp_lo = e.lo;
        n_cmp += 3;
        if (bus.HI !== e.hi) begin
            n_err++; $display("FAIL %s HI: got %h, required %h", name, bus.HI, e.hi);
        end
        if (bus.LO !== e.lo) begin
            n_err++; $display("FAIL %s LO: got %h, required %h", name, bus.LO, e.lo);
        end
        if (bus.DivByZero !== e.dbz) begin
            n_err++; $display("FAIL %s DivByZero: got %b, required %b", name, bus.DivByZero, e.dbz);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.Start = 0; bus.MDOperation = 0; bus.A = 0; bus.B = 0;
        bus.HIWrite = 0; bus.LOWrite = 0; bus.WriteData = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.HI, bus.LO, bus.Busy, bus.Done, bus.DivByZero} !== 67'd0) begin
            n_err++;
            $display("FAIL reset_state: HI=%h LO=%h Busy=%b Done=%b DBZ=%b, required all zero",
                     bus.HI, bus.LO, bus.Busy, bus.Done, bus.DivByZero);
        end
        reset = 1'b0;
    endtask

    task automatic test_multu_max;
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_cmp++;
        if (bus.Busy !== 1'b1) begin
            n_err++; $display("FAIL multu_busy: got %b, required 1", bus.Busy);
        end
        wait_result("multu_max");
        @(negedge clk);
        n_cmp++;
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
            n_err++; $display("FAIL done_pulse: Done=%b Busy=%b, required 0 0", bus.Done, bus.Busy);
        end
    endtask

    task automatic test_signed;
        start_op(2'b00, -32'sd3, 32'sd5);           wait_result("mult_neg");
        start_op(2'b10, -32'sd7, 32'sd2);           wait_result("div_neg");
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_result("div_ovf");
        start_op(2'b10, 32'sd7, -32'sd2);           wait_result("div_negb");
    endtask

    task automatic test_div_zero;
        start_op(2'b11, 32'd7, 32'd0);          wait_result("divu_zero");
        start_op(2'b10, 32'hFFFF_FFF0, 32'd0);  wait_result("div_zero");
    endtask

    task automatic test_busy_ignore;
        start_op(2'b01, 32'd2, 32'd3);
        repeat (9) @(negedge clk);
        bus.Start = 1'b1; bus.MDOperation = 2'b11; bus.A = 32'd9; bus.B = 32'd3;
        bus.HIWrite = 1'b1; bus.WriteData = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.Start = 1'b0; bus.HIWrite = 1'b0;
        n_cmp++;
        if (bus.HI !== exp_hi) begin
            n_err++; $display("FAIL busy_hiwrite: HI=%h, required %h", bus.HI, exp_hi);
        end
        wait_result("busy_ignore");
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.Busy !== 1'b0) begin
            n_err++; $display("FAIL busy_start_ignored: Busy=%b, required 0", bus.Busy);
        end
    endtask

    task automatic test_back_to_back;
        start_op(2'b01, 32'd1000, 32'd1000);
        wait_result("b2b_first");
        bus.Start = 1'b1; bus.MDOperation = 2'b11; bus.A = 32'd100; bus.B = 32'd7;
        sb.push_back(model(2'b11, 32'd100, 32'd7));
        @(negedge clk);
        bus.Start = 1'b0;
        e0 = cycle;
        n_cmp++;
        if (bus.Busy !== 1'b1) begin
            n_err++; $display("FAIL b2b_accept: Busy=%b, required 1", bus.Busy);
        end
        wait_result("b2b_second");
    endtask

    task automatic test_write_with_start;
        @(negedge clk);
        bus.Start = 1'b1; bus.MDOperation = 2'b01; bus.A = 32'd5; bus.B = 32'd7;
        bus.HIWrite = 1'b1; bus.WriteData = 32'hCAFE_F00D;
        sb.push_back(model(2'b01, 32'd5, 32'd7));
        @(negedge clk);
        bus.Start = 1'b0; bus.HIWrite = 1'b0;
        e0 = cycle;
        n_cmp++;
        if (bus.HI !== 32'hCAFE_F00D || bus.Busy !== 1'b1) begin
            n_err++; $display("FAIL write_with_start: HI=%h Busy=%b, required cafef00d 1", bus.HI, bus.Busy);
        end
        wait_result("write_with_start");
    endtask

    task automatic test_mtlo;
        @(negedge clk);
        bus.LOWrite = 1'b1; bus.WriteData = 32'h1234_5678;
        @(negedge clk);
        bus.LOWrite = 1'b0;
        n_cmp++;
        if (bus.LO !== 32'h1234_5678 || bus.HI !== exp_hi || bus.Busy !== 1'b0) begin
            n_err++;
            $display("FAIL mtlo: LO=%h HI=%h Busy=%b, required 12345678 %h 0", bus.LO, bus.HI, bus.Busy, exp_hi);
        end
        exp_lo = 32'h1234_5678;
    endtask

    task automatic test_reset_abort;
        int dones;
        start_op(2'b01, 32'd4, 32'd4);
        void'(sb.pop_back());
        repeat (14) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.HI, bus.LO, bus.Busy, bus.Done} !== 66'd0) begin
            n_err++;
            $display("FAIL reset_abort: HI=%h LO=%h Busy=%b Done=%b, required all zero",
                     bus.HI, bus.LO, bus.Busy, bus.Done);
        end
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.Done === 1'b1) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_err++; $display("FAIL reset_no_done: got %0d Done pulses, required 0", dones);
        end
        start_op(2'b01, 32'd4, 32'd4);
        wait_result("after_reset");
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            if (i % 6 == 1) b = -b;
            if (i == 5) b = 32'd0;
            start_op(op, a, b);
            wait_result($sformatf("random_%0d_op%0d", i, op));
        end
    endtask

    initial begin
        test_reset;
        test_multu_max;
        test_signed;
        test_div_zero;
        test_busy_ignore;
        test_back_to_back;
        test_write_with_start;
        test_mtlo;
        test_reset_abort;
        test_random;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
